// File: rtl/bus_cycle_arbiter.sv
// Two-requester master for an 8088-style multiplexed bus: arbitrates, then runs T1-T2-T3-(TW)-T4-TI.
// Optional build macro BUSARB_FIXED_PRIO_EN gives requester 0 fixed priority instead of round-robin.
//
//  state | meaning
//  IDLE  | no cycle; arbitrate every clock
//  T1    | ALE high, chip select and address presented
//  T2    | RD or WR asserted; write data driven onto AD
//  T3    | strobes held
//  TW    | strobes held for WAIT_STATES clocks
//  T4    | strobes released, chip select held, DONE to the granted requester
//  TI    | turnaround, bus released; arbitrate for the next cycle
module bus_cycle_arbiter #(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ0,
  input  logic        WE0,
  input  logic        IOM0,
  input  logic [19:0] ADDR0,
  input  logic [7:0]  WDATA0,
  output logic        DONE0,
  input  logic        REQ1,
  input  logic        WE1,
  input  logic        IOM1,
  input  logic [19:0] ADDR1,
  input  logic [7:0]  WDATA1,
  output logic        DONE1,
  output logic [7:0]  RDATA,
  output logic        ALE,
  output logic        RD,
  output logic        WR,
  output logic        MEMCS,
  output logic        IOCS,
  output logic [19:0] ADDR,
  inout  wire  [7:0]  AD
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T1   = 3'd1;
  localparam logic [2:0] S_T2   = 3'd2;
  localparam logic [2:0] S_T3   = 3'd3;
  localparam logic [2:0] S_TW   = 3'd4;
  localparam logic [2:0] S_T4   = 3'd5;
  localparam logic [2:0] S_TI   = 3'd6;

  localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  logic [2:0]  state, state_nx;
  logic [2:0]  ws_cnt;
  logic        gnt_q;
  logic        we_q, iom_q;
  logic [19:0] addr_q;
  logic [7:0]  wdata_q;
  logic        arb, any_req, pick;
  logic        in_cyc, strobe, ad_oe, capture;

  assign arb     = (state == S_IDLE) || (state == S_TI);
  assign any_req = REQ0 | REQ1;

`ifdef BUSARB_FIXED_PRIO_EN
  assign pick = ~REQ0;
`else
  logic last;
  // last-grant pointer starts at 1 so requester 0 wins the first tie
  assign pick = (REQ0 & REQ1) ? ~last : REQ1;

  always_ff @(posedge CLK) begin
    if (RESET)
      last <= 1'b1;
    else if (arb && any_req)
      last <= pick;
  end
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_TI: state_nx = any_req ? S_T1 : S_IDLE;
      S_T1:         state_nx = S_T2;
      S_T2:         state_nx = S_T3;
      S_T3:         state_nx = (WAIT_STATES > 0) ? S_TW : S_T4;
      S_TW:         state_nx = (ws_cnt == 3'd0) ? S_T4 : S_TW;
      S_T4:         state_nx = S_TI;
      default:      state_nx = S_IDLE;
    endcase
  end

  assign capture = ((state == S_T3) || (state == S_TW)) && (state_nx == S_T4) && !we_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= S_IDLE;
      ws_cnt  <= 3'd0;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      iom_q   <= 1'b0;
      addr_q  <= 20'h0;
      wdata_q <= 8'h0;
      RDATA   <= 8'h0;
    end else begin
      state <= state_nx;
      if (state == S_T3)
        ws_cnt <= WS_LOAD;
      else if (state == S_TW)
        ws_cnt <= ws_cnt - 3'd1;
      if (arb && any_req) begin
        gnt_q   <= pick;
        we_q    <= pick ? WE1    : WE0;
        iom_q   <= pick ? IOM1   : IOM0;
        addr_q  <= pick ? ADDR1  : ADDR0;
        wdata_q <= pick ? WDATA1 : WDATA0;
      end
      if (capture)
        RDATA <= AD;
    end
  end

  // Everything on the bus is decoded from the state and the fields latched at grant
  assign in_cyc = (state == S_T1) || (state == S_T2) || (state == S_T3) ||
                  (state == S_TW) || (state == S_T4);
  assign strobe = (state == S_T2) || (state == S_T3) || (state == S_TW);
  assign ad_oe  = we_q && (strobe || (state == S_T4));

  assign ALE   = (state == S_T1);
  assign RD    = ~(strobe & ~we_q);
  assign WR    = ~(strobe & we_q);
  assign MEMCS = in_cyc & ~iom_q;
  assign IOCS  = in_cyc & iom_q;
  assign ADDR  = !in_cyc ? 20'h0 : (iom_q ? {4'h0, addr_q[15:0]} : addr_q);
  assign AD    = ad_oe ? wdata_q : 8'bz;
  assign DONE0 = (state == S_T4) & ~gnt_q;
  assign DONE1 = (state == S_T4) & gnt_q;

endmodule

// File: tb/tb_bus_cycle_arbiter.sv
// Bench for bus_cycle_arbiter: directed transfers, contention ordering, mid-cycle reset,
// then random traffic against a transfer-level model (phase index within a fixed-length transfer).
module tb_bus_cycle_arbiter;

  localparam int WS  = 2;
  localparam int LEN = 5 + WS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 0, we0 = 0, iom0 = 0, req1 = 0, we1 = 0, iom1 = 0;
  logic [19:0] addr0 = 0, addr1 = 0;
  logic [7:0]  wdata0 = 0, wdata1 = 0;
  logic        done0, done1, ale, rd, wr, memcs, iocs;
  logic [7:0]  rdata;
  logic [19:0] addr;
  wire  [7:0]  ad;
  logic [7:0]  dev_data = 8'h00;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // device drives the data bus whenever it sees RD low
  assign ad = (rd == 1'b0) ? dev_data : 8'bz;

  bus_cycle_arbiter #(.WAIT_STATES(WS)) dut (
    .CLK(clk), .RESET(rst),
    .REQ0(req0), .WE0(we0), .IOM0(iom0), .ADDR0(addr0), .WDATA0(wdata0), .DONE0(done0),
    .REQ1(req1), .WE1(we1), .IOM1(iom1), .ADDR1(addr1), .WDATA1(wdata1), .DONE1(done1),
    .RDATA(rdata), .ALE(ale), .RD(rd), .WR(wr), .MEMCS(memcs), .IOCS(iocs),
    .ADDR(addr), .AD(ad)
  );

  always #5 clk = ~clk;

  // reference: one transfer = phases 0..LEN-1 (T1, T2, T3, WS waits, T4, TI)
  bit          m_busy = 0;
  int          m_ph   = 0;
  int          m_who  = 0;
  int          m_last = 1;
  bit          m_we = 0, m_iom = 0;
  logic [19:0] m_addr = 0;
  logic [7:0]  m_wd = 0, m_rdata = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy  = 0;
      m_last  = 1;
      m_rdata = 8'h00;
    end else begin
      if (m_busy && m_ph == 2 + WS && !m_we)
        m_rdata = dev_data;
      if (m_busy && m_ph < LEN - 1) begin
        m_ph++;
      end else if (req0 || req1) begin
`ifdef BUSARB_FIXED_PRIO_EN
        m_who = req0 ? 0 : 1;
`else
        m_who = (req0 && req1) ? 1 - m_last : (req0 ? 0 : 1);
`endif
        m_last = m_who;
        m_busy = 1;
        m_ph   = 0;
        m_we   = (m_who == 0) ? we0 : we1;
        m_iom  = (m_who == 0) ? iom0 : iom1;
        m_addr = (m_who == 0) ? addr0 : addr1;
        m_wd   = (m_who == 0) ? wdata0 : wdata1;
      end else begin
        m_busy = 0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    bit act, strb, cs_e;
    int ph;
    @(negedge clk);
    act  = m_busy;
    ph   = m_ph;
    strb = act && ph >= 1 && ph <= 2 + WS;
    cs_e = act && ph <= 3 + WS;
    check_eq("ale",   32'(ale),   32'(act && ph == 0));
    check_eq("rd",    32'(rd),    32'(!(strb && !m_we)));
    check_eq("wr",    32'(wr),    32'(!(strb && m_we)));
    check_eq("memcs", 32'(memcs), 32'(cs_e && !m_iom));
    check_eq("iocs",  32'(iocs),  32'(cs_e && m_iom));
    check_eq("addr",  32'(addr),  32'(!cs_e ? 20'h0 : (m_iom ? {4'h0, m_addr[15:0]} : m_addr)));
    check_eq("done0", 32'(done0), 32'(act && ph == 3 + WS && m_who == 0));
    check_eq("done1", 32'(done1), 32'(act && ph == 3 + WS && m_who == 1));
    check_eq("rdata", 32'(rdata), 32'(m_rdata));
    if (act && m_we && ph >= 1 && ph <= 3 + WS)
      check_eq("ad_wr", 32'(ad), 32'(m_wd));
    cyc++;
  endtask

  logic [19:0] lat_addr;
  logic [7:0]  lat_wd;

  task automatic xfer(input int r, input bit we, input bit iom, input logic [19:0] a,
                      input logic [7:0] wd, input logic [7:0] dv, output bit ok);
    ok = 0;
    dev_data = dv;
    if (r == 0) begin req0 = 1; we0 = we; iom0 = iom; addr0 = a; wdata0 = wd; end
    else        begin req1 = 1; we1 = we; iom1 = iom; addr1 = a; wdata1 = wd; end
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      if (ale) lat_addr = addr;
      if (!wr) lat_wd = ad;
      if ((r == 0) ? done0 : done1) ok = 1;
    end
    req0 = 0;
    req1 = 0;
    step();
  endtask

  int grants[$];
  int ale_at[$];
  bit ok;

  initial begin
    step();
    step();
    check_eq("rst_rd",  32'(rd), 32'd1);
    check_eq("rst_wr",  32'(wr), 32'd1);
    check_eq("rst_cs",  32'({memcs, iocs}), 32'd0);
    rst = 0;
    step();

    xfer(0, 0, 0, 20'h01234, 8'h00, 8'hA5, ok);
    check_eq("rd_done", 32'(ok), 32'd1);
    check_eq("rd_addr", 32'(lat_addr), 32'h01234);
    check_eq("rd_data", 32'(rdata), 32'hA5);

    xfer(1, 1, 1, 20'hF0F0, 8'h3C, 8'h00, ok);
    check_eq("wr_done", 32'(ok), 32'd1);
    check_eq("wr_addr", 32'(lat_addr), 32'h0F0F0);
    check_eq("wr_data", 32'(lat_wd), 32'h3C);

    // reset while a write sits in T3
    req0 = 1; we0 = 1; iom0 = 0; addr0 = 20'h00ABC; wdata0 = 8'h77;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      if (m_busy && m_ph == 2) ok = 1;
    end
    check_eq("t3_reach", 32'(ok), 32'd1);
    rst = 1;
    req0 = 0;
    step();
    check_eq("rst_t3_wr",   32'(wr), 32'd1);
    check_eq("rst_t3_cs",   32'({memcs, iocs}), 32'd0);
    check_eq("rst_t3_done", 32'({done0, done1}), 32'd0);
    rst = 0;
    step();
    step();
    check_eq("rst_t3_idle", 32'({ale, memcs, iocs}), 32'd0);

    // contention: both requesters held, pointer freshly reset
    rst = 1;
    step();
    rst = 0;
    req0 = 1; we0 = 0; iom0 = 0; addr0 = 20'h11111;
    req1 = 1; we1 = 0; iom1 = 1; addr1 = 20'h22222;
    for (int i = 0; i < 100 && grants.size() < 4; i++) begin
      step();
      if (ale) ale_at.push_back(cyc);
      if (done0) grants.push_back(0);
      if (done1) grants.push_back(1);
    end
    check_eq("cont_cnt", 32'(grants.size()), 32'd4);
    for (int k = 0; k < 4 && k < grants.size(); k++)
`ifdef BUSARB_FIXED_PRIO_EN
      check_eq($sformatf("grant%0d", k), 32'(grants[k]), 32'd0);
`else
      check_eq($sformatf("grant%0d", k), 32'(grants[k]), 32'(k % 2));
`endif
    for (int k = 1; k < 4 && k < ale_at.size(); k++)
      check_eq($sformatf("t1_gap%0d", k), 32'(ale_at[k] - ale_at[k-1]), 32'(LEN));
    req0 = 0;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      if (done1) ok = 1;
    end
    check_eq("req1_after", 32'(ok), 32'd1);
    req1 = 0;
    step();
    step();

    // random traffic; a granted requester holds REQ until it sees DONE
    for (int n = 0; n < 4000; n++) begin
      step();
      rst = ($urandom_range(0, 149) == 0);
      if (m_busy && m_ph == 0) dev_data = 8'($urandom);
      if (!(m_busy && m_who == 0 && m_ph < 3 + WS)) req0 = ($urandom_range(0, 2) != 0);
      if (!(m_busy && m_who == 1 && m_ph < 3 + WS)) req1 = ($urandom_range(0, 2) != 0);
      we0 = 1'($urandom); iom0 = 1'($urandom); addr0 = 20'($urandom); wdata0 = 8'($urandom);
      we1 = 1'($urandom); iom1 = 1'($urandom); addr1 = 20'($urandom); wdata1 = 8'($urandom);
    end
    rst = 0;
    req0 = 0;
    req1 = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
